// File: rtl/vga_ball_pkg.sv
// Shared constants and types for the VGA ball frame scheduler.
// Register map, ctrl bit positions, reset values and the sequencer state encoding.
package vga_ball_pkg;

  localparam logic [2:0] A_BG_R  = 3'd0;
  localparam logic [2:0] A_BG_G  = 3'd1;
  localparam logic [2:0] A_BG_B  = 3'd2;
  localparam logic [2:0] A_CTRL  = 3'd3;
  localparam logic [2:0] A_VEL_X = 3'd4;
  localparam logic [2:0] A_VEL_Y = 3'd5;
  localparam logic [2:0] A_POS_X = 3'd6;
  localparam logic [2:0] A_POS_Y = 3'd7;

  localparam int C_RUN     = 0;
  localparam int C_IRQ_EN  = 1;
  localparam int C_STEP    = 2;
  localparam int C_IRQ_CLR = 3;

  localparam logic [7:0] RST_BG_R = 8'h00;
  localparam logic [7:0] RST_BG_G = 8'h00;
  localparam logic [7:0] RST_BG_B = 8'h80;
  localparam logic [9:0] RST_X    = 10'd320;
  localparam logic [9:0] RST_Y    = 10'd240;

  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, COMMIT} state_t;

  function automatic logic [9:0] clamp10(input logic [9:0] v, input int lo, input int hi);
    if (int'(v) < lo) return 10'(lo);
    if (int'(v) > hi) return 10'(hi);
    return v;
  endfunction

endpackage

// File: rtl/vga_axis_bounce.sv
// One-axis ball step: pos + signed vel, reflected off [RADIUS, LIMIT-1-RADIUS].
// Purely combinational; velocity is negated on a bounce, with -128 saturating to +127.
module vga_axis_bounce #(
  parameter int LIMIT  = 640,
  parameter int RADIUS = 16
) (
  input  logic [9:0] pos,
  input  logic [7:0] vel,
  output logic [9:0] next_pos,
  output logic [7:0] next_vel
);

  localparam logic signed [11:0] LO = 12'(RADIUS);
  localparam logic signed [11:0] HI = 12'(LIMIT - 1 - RADIUS);

  logic signed [11:0] n;
  logic [7:0]         neg_vel;

  assign n       = $signed({2'b00, pos}) + $signed({{4{vel[7]}}, vel});
  assign neg_vel = (vel == 8'h80) ? 8'h7f : (~vel + 8'd1);

  always_comb begin
    next_pos = n[9:0];
    next_vel = vel;
    if (n < LO) begin
      next_pos = 10'((LO <<< 1) - n);
      next_vel = neg_vel;
    end else if (n > HI) begin
      next_pos = 10'((HI <<< 1) - n);
      next_vel = neg_vel;
    end
  end

endmodule

// File: rtl/vga_ball_sched.sv
// Shadowed Avalon register file committed at vertical blanking, plus once-per-frame ball motion.
// Commit lands 3 cycles after the frame tick; writes have zero wait states, reads 1 cycle latency.
module vga_ball_sched
  import vga_ball_pkg::*;
#(
  parameter int RADIUS  = 16,
  parameter int HACTIVE = 640,
  parameter int VACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [7:0]  bg_r,
  output logic [7:0]  bg_g,
  output logic [7:0]  bg_b,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic        irq
);

  state_t     state;
  logic       run, irq_en, step_pending;
  logic [7:0] pend;
  logic [7:0] sh [8];
  logic [7:0] vel_x, vel_y;
  logic [9:0] nx, ny;
  logic [7:0] nvx, nvy;

  logic       wr, rd, tick, busy, any_pending, moving, ctrl_wr;
  logic [7:0] vx_use, vy_use, bx_vel, by_vel, vx_next, vy_next, rd_mux;
  logic [9:0] bx_pos, by_pos, x_next, y_next;

  assign wr          = chipselect & write;
  assign rd          = chipselect & read;
  assign ctrl_wr     = wr && (address == A_CTRL);
  assign tick        = (hcount == 11'd1599) && (vcount == 10'(VACTIVE - 1));
  assign busy        = (state != IDLE);
  assign any_pending = |pend;
  assign moving      = run | step_pending;

  // A velocity written this frame is used for this frame's motion.
  assign vx_use = pend[A_VEL_X] ? sh[A_VEL_X] : vel_x;
  assign vy_use = pend[A_VEL_Y] ? sh[A_VEL_Y] : vel_y;

  vga_axis_bounce #(.LIMIT(HACTIVE), .RADIUS(RADIUS)) u_bounce_x (
    .pos(ball_x), .vel(vx_use), .next_pos(bx_pos), .next_vel(bx_vel)
  );

  vga_axis_bounce #(.LIMIT(VACTIVE), .RADIUS(RADIUS)) u_bounce_y (
    .pos(ball_y), .vel(vy_use), .next_pos(by_pos), .next_vel(by_vel)
  );

  always_comb begin
    x_next  = ball_x;
    vx_next = vx_use;
    if (pend[A_POS_X])
      x_next = clamp10({sh[A_POS_X], 2'b00}, RADIUS, HACTIVE - 1 - RADIUS);
    else if (moving) begin
      x_next  = bx_pos;
      vx_next = bx_vel;
    end
  end

  always_comb begin
    y_next  = ball_y;
    vy_next = vy_use;
    if (pend[A_POS_Y])
      y_next = clamp10({1'b0, sh[A_POS_Y], 1'b0}, RADIUS, VACTIVE - 1 - RADIUS);
    else if (moving) begin
      y_next  = by_pos;
      vy_next = by_vel;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (address)
      A_BG_R:  rd_mux = bg_r;
      A_BG_G:  rd_mux = bg_g;
      A_BG_B:  rd_mux = bg_b;
      A_CTRL:  rd_mux = {irq, busy, any_pending, 2'b00, step_pending, irq_en, run};
      A_VEL_X: rd_mux = vel_x;
      A_VEL_Y: rd_mux = vel_y;
      A_POS_X: rd_mux = ball_x[9:2];
      A_POS_Y: rd_mux = ball_y[9:1];
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      run          <= 1'b0;
      irq_en       <= 1'b0;
      step_pending <= 1'b0;
      irq          <= 1'b0;
      pend         <= '0;
      for (int i = 0; i < 8; i++) sh[i] <= 8'h00;
      vel_x        <= 8'h00;
      vel_y        <= 8'h00;
      nx           <= RST_X;
      ny           <= RST_Y;
      nvx          <= 8'h00;
      nvy          <= 8'h00;
      ball_x       <= RST_X;
      ball_y       <= RST_Y;
      bg_r         <= RST_BG_R;
      bg_g         <= RST_BG_G;
      bg_b         <= RST_BG_B;
      readdata     <= 8'h00;
    end else begin
      // Each axis clears its own flags when consumed, so a write landing in a
      // later sequence cycle survives to the next frame.
      case (state)
        IDLE: if (tick) state <= MOVE_X;
        MOVE_X: begin
          nx            <= x_next;
          nvx           <= vx_next;
          pend[A_POS_X] <= 1'b0;
          pend[A_VEL_X] <= 1'b0;
          state         <= MOVE_Y;
        end
        MOVE_Y: begin
          ny            <= y_next;
          nvy           <= vy_next;
          pend[A_POS_Y] <= 1'b0;
          pend[A_VEL_Y] <= 1'b0;
          state         <= COMMIT;
        end
        COMMIT: begin
          if (pend[A_BG_R]) bg_r <= sh[A_BG_R];
          if (pend[A_BG_G]) bg_g <= sh[A_BG_G];
          if (pend[A_BG_B]) bg_b <= sh[A_BG_B];
          ball_x        <= nx;
          ball_y        <= ny;
          vel_x         <= nvx;
          vel_y         <= nvy;
          pend[A_BG_R]  <= 1'b0;
          pend[A_BG_G]  <= 1'b0;
          pend[A_BG_B]  <= 1'b0;
          step_pending  <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (wr) begin
        if (address == A_CTRL) begin
          run    <= writedata[C_RUN];
          irq_en <= writedata[C_IRQ_EN];
          if (writedata[C_STEP]) step_pending <= 1'b1;
        end else begin
          sh[address]   <= writedata;
          pend[address] <= 1'b1;
        end
      end

      if (state == COMMIT && irq_en)
        irq <= 1'b1;
      else if (ctrl_wr && (writedata[C_IRQ_CLR] || !writedata[C_IRQ_EN]))
        irq <= 1'b0;

      if (rd) readdata <= rd_mux;
    end
  end

endmodule
